// File: rtl/ntt_pkg.sv
// Shared NTT package: default data width/depth and sizing helpers.
// Used by ntt_drain_fifo, its interface and its storage sub-module.
package ntt_pkg;

    localparam int unsigned NTT_WIDTH  = 96;
    localparam int unsigned NTT_FDEPTH = 8;

    // Bits needed to hold an occupancy value in 0..depth.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to address depth entries (at least 1).
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ntt_drain_fifo_if.sv
// Bus between the enable-gated NTT pipeline, the drain FIFO and its consumer.
//   in_valid/in_data : word from the upstream pipeline (no back-pressure)
//   pipe_en          : advance permission back to the upstream pipeline
//   out_valid/out_ready/out_data : downstream handshake
//   count            : current FIFO occupancy
// master = producer/consumer side, slave = FIFO side.
interface ntt_drain_fifo_if
    import ntt_pkg::*;
#(
    parameter int unsigned WIDTH  = NTT_WIDTH,
    parameter int unsigned FDEPTH = NTT_FDEPTH
);

    localparam int unsigned CW = cnt_w(FDEPTH);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             pipe_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, in_data, out_ready,
        input  pipe_en, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output pipe_en, out_valid, out_data, count
    );

endinterface

// File: rtl/ntt_drain_ram.sv
// Simple dual-port storage array for the drain FIFO: synchronous write,
// asynchronous read. Contents are not reset.
//   clk                 : clock
//   we/waddr/wdata      : write port
//   raddr/rdata         : read port (combinational)
module ntt_drain_ram
    import ntt_pkg::*;
#(
    parameter int unsigned WIDTH = NTT_WIDTH,
    parameter int unsigned DEPTH = NTT_FDEPTH,
    parameter int unsigned AW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Fall-through read port.
    assign rdata = mem[raddr];

endmodule

// File: rtl/ntt_drain_fifo.sv
// Drain FIFO behind an enable-gated NTT pipeline. Words arrive without
// back-pressure; pipe_en throttles the pipeline early enough that the one
// word still in flight after en drops always fits.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ntt_drain_fifo_if.slave (in_valid/in_data, pipe_en,
//                out_valid/out_ready/out_data, count)
//   err        : sticky dropped-push flag, only with NTT_DRAIN_ERR_EN defined
module ntt_drain_fifo
    import ntt_pkg::*;
#(
    parameter int unsigned WIDTH  = NTT_WIDTH,
    parameter int unsigned FDEPTH = NTT_FDEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    ntt_drain_fifo_if.slave   bus
`ifdef NTT_DRAIN_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int unsigned CW = cnt_w(FDEPTH);
    localparam int unsigned PW = ptr_w(FDEPTH);

    localparam logic [PW-1:0] PTR_LAST = PW'(FDEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FDEPTH);
    localparam logic [CW-1:0] CNT_EN   = CW'(FDEPTH - 2);

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rd_data_c;
    logic             full_c;
    logic             nonempty_c;
    logic             pop_c;
    logic             push_c;

    // Push/pop qualification; a full FIFO still accepts when it pops.
    assign full_c     = (count == CNT_FULL);
    assign nonempty_c = (count != '0);
    assign pop_c      = nonempty_c && bus.out_ready;
    assign push_c     = bus.in_valid && (!full_c || pop_c);

    // Pointers and occupancy; pointers wrap explicitly for any depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_c) begin
                wptr <= (wptr == PTR_LAST) ? '0 : wptr + PW'(1);
            end
            if (pop_c) begin
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + PW'(1);
            end
            unique case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    ntt_drain_ram #(
        .WIDTH (WIDTH),
        .DEPTH (FDEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (push_c),
        .waddr (wptr),
        .wdata (bus.in_data),
        .raddr (rptr),
        .rdata (rd_data_c)
    );

    // Outputs decode the occupancy register; empty reads as zero so stale or
    // uninitialised storage never reaches out_data.
    assign bus.count     = count;
    assign bus.out_valid = nonempty_c;
    assign bus.out_data  = nonempty_c ? rd_data_c : '0;
    assign bus.pipe_en   = (count <= CNT_EN);

`ifdef NTT_DRAIN_ERR_EN
    // Sticky flag for a push lost at full occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (bus.in_valid && full_c && !pop_c) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ntt_drain_fifo.sv
// Bench for ntt_drain_fifo: an FDEPTH=8 and an FDEPTH=5 instance compared
// each cycle against queue-based reference models.
// Define NTT_DRAIN_ERR_EN to include the err port checks.
module tb_ntt_drain_fifo;
    import ntt_pkg::*;

    localparam int unsigned W = 96;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ntt_drain_fifo_if #(.WIDTH(W), .FDEPTH(8)) b8 ();
    ntt_drain_fifo_if #(.WIDTH(W), .FDEPTH(5)) b5 ();

`ifdef NTT_DRAIN_ERR_EN
    logic err8;
    logic err5;
`endif

    ntt_drain_fifo #(.WIDTH(W), .FDEPTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
`ifdef NTT_DRAIN_ERR_EN
        ,
        .err   (err8)
`endif
    );

    ntt_drain_fifo #(.WIDTH(W), .FDEPTH(5)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b5)
`ifdef NTT_DRAIN_ERR_EN
        ,
        .err   (err5)
`endif
    );

    logic [W-1:0] q8[$];
    logic [W-1:0] q5[$];
    bit           err8_m;
    bit           err5_m;
    int           ntests;
    int           nfail;

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag);
        int sz;
        sz = q8.size();
        chk({tag, " d8.count"}, W'(b8.count), W'(sz));
        chk({tag, " d8.out_valid"}, W'(b8.out_valid), W'(sz > 0));
        chk({tag, " d8.out_data"}, b8.out_data, (sz > 0) ? q8[0] : '0);
        chk({tag, " d8.pipe_en"}, W'(b8.pipe_en), W'(sz <= 6));
`ifdef NTT_DRAIN_ERR_EN
        chk({tag, " d8.err"}, W'(err8), W'(err8_m));
`endif
    endtask

    task automatic check5(input string tag);
        int sz;
        sz = q5.size();
        chk({tag, " d5.count"}, W'(b5.count), W'(sz));
        chk({tag, " d5.out_valid"}, W'(b5.out_valid), W'(sz > 0));
        chk({tag, " d5.out_data"}, b5.out_data, (sz > 0) ? q5[0] : '0);
        chk({tag, " d5.pipe_en"}, W'(b5.pipe_en), W'(sz <= 3));
`ifdef NTT_DRAIN_ERR_EN
        chk({tag, " d5.err"}, W'(err5), W'(err5_m));
`endif
    endtask

    // One clock on the depth-8 instance; model follows the push/pop rules.
    task automatic step8(input string tag, input bit iv, input logic [W-1:0] d, input bit rdy);
        bit pop;
        bit push;
        int sz;
        b8.in_valid  = iv;
        b8.in_data   = d;
        b8.out_ready = rdy;
        sz   = q8.size();
        pop  = (sz > 0) && rdy;
        push = iv && ((sz < 8) || pop);
        if (iv && !push) err8_m = 1'b1;
        @(posedge clk);
        if (pop)  void'(q8.pop_front());
        if (push) q8.push_back(d);
        #1;
        check8(tag);
    endtask

    // One clock on the depth-5 instance; reports the DUT word seen on a pop.
    task automatic step5(input string tag, input bit iv, input logic [W-1:0] d, input bit rdy,
                         output bit pushed, output bit popped, output logic [W-1:0] pop_word);
        int sz;
        b5.in_valid  = iv;
        b5.in_data   = d;
        b5.out_ready = rdy;
        sz       = q5.size();
        popped   = (sz > 0) && rdy;
        pushed   = iv && ((sz < 5) || popped);
        pop_word = b5.out_data;
        if (iv && !pushed) err5_m = 1'b1;
        @(posedge clk);
        if (popped) void'(q5.pop_front());
        if (pushed) q5.push_back(d);
        #1;
        check5(tag);
    endtask

    // Assert reset away from a clock edge and check the immediate effect.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        q8.delete();
        q5.delete();
        err8_m = 1'b0;
        err5_m = 1'b0;
        #1;
        check8(tag);
        check5(tag);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit               en_now;
        bit               last_en;
        bit               pu;
        bit               po;
        logic [W-1:0]     pw;
        int               idx;
        int               npop;
        int               cyc;

        ntests = 0;
        nfail  = 0;
        err8_m = 1'b0;
        err5_m = 1'b0;
        b8.in_valid = 1'b0; b8.in_data = '0; b8.out_ready = 1'b0;
        b5.in_valid = 1'b0; b5.in_data = '0; b5.out_ready = 1'b0;

        // Reset state
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check8("reset");
        check5("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Three pushes with consumer stalled
        step8("push1", 1'b1, W'(1), 1'b0);
        step8("push2", 1'b1, W'(2), 1'b0);
        step8("push3", 1'b1, W'(3), 1'b0);
        chk("three-push head", b8.out_data, W'(1));

        // Upstream follows pipe_en with one cycle of lag until it stops
        last_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            en_now = (q8.size() <= 6);
            step8("fill-en", last_en, rnd_word(), 1'b0);
            last_en = en_now;
        end
        chk("fill count", W'(b8.count), W'(8));

        // Simultaneous push and pop at full
        for (int i = 0; i < 4; i++) step8("full-pushpop", 1'b1, rnd_word(), 1'b1);
        chk("full-pushpop count", W'(b8.count), W'(8));
        for (int i = 0; i < 10; i++) step8("drain", 1'b0, rnd_word(), 1'b1);

        // Random traffic, drops allowed
        for (int i = 0; i < 150; i++)
            step8("rand8", 1'($urandom_range(0, 1)), rnd_word(), 1'($urandom_range(0, 1)));

        // Overfill: pushes at full are dropped
        for (int i = 0; i < 10; i++) step8("overfill", 1'b1, rnd_word(), 1'b0);
        chk("overfill count", W'(b8.count), W'(8));
        for (int i = 0; i < 3; i++) step8("post-drop idle", 1'b0, '0, 1'b0);
        async_reset("reset-after-drop");

        // Reset mid-stream at count 4
        for (int i = 0; i < 4; i++) step8("pre-reset", 1'b1, rnd_word(), 1'b0);
        chk("pre-reset count", W'(b8.count), W'(4));
        async_reset("mid-reset");
        step8("post-reset", 1'b1, W'('hAA), 1'b0);
        chk("post-reset head", b8.out_data, W'('hAA));
        step8("post-reset idle", 1'b0, '0, 1'b1);

        // Depth-5 ordered stream 0..19 with random consumer
        idx     = 0;
        npop    = 0;
        cyc     = 0;
        last_en = 1'b1;
        while (npop < 20 && cyc < 500) begin
            en_now = (q5.size() <= 3);
            step5("stream5", last_en && (idx < 20), W'(idx), 1'($urandom_range(0, 1)), pu, po, pw);
            if (pu) idx++;
            if (po) begin
                chk("stream5 order", pw, W'(npop));
                npop++;
            end
            last_en = en_now;
            cyc++;
        end
        chk("stream5 popped", W'(npop), W'(20));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
